// File: rtl/bf16_share_arbiter.sv
// Round-robin share of one BF16Unit between NREQ requesters. An in-order tag FIFO
// records who owns each in-flight op so results return to their issuer; abort flushes it.
module bf16_share_arbiter #(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TW              = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_opc,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sqrt,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_y,
  input  logic                 abort,
  output logic                 busy,
  output logic                 err_spurious,
  output logic [1:0]           bf16_opc,
  output logic [15:0]          bf16_a,
  output logic [15:0]          bf16_b,
  output logic                 bf16_isSqrt,
  output logic                 bf16_iv,
  input  logic                 bf16_ir,
  input  logic [15:0]          bf16_y,
  input  logic                 bf16_ov,
  output logic                 bf16_or,
  output logic                 bf16_kill
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [TW-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [TW-1:0]       rr_ptr, lock_id, grant, cand, head;
  logic                lock, kill_q, err_q;
  logic                full, nonempty, issue_en, has_req, accept, pop, spurious;
  logic [2*NREQ-1:0]   opc_sh;
  logic [16*NREQ-1:0]  a_sh, b_sh;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(MAX_OUTSTANDING));
  assign nonempty = (count != '0);
  assign issue_en = !full && !kill_q && !abort;
  assign head     = tag_mem[rd_ptr];

  // A stalled grant is locked so the payload presented to the unit cannot switch owners.
  always_comb begin
    grant   = rr_ptr;
    cand    = '0;
    has_req = 1'b0;
    if (lock) begin
      grant   = lock_id;
      has_req = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = TW'((32'(rr_ptr) + k) % NREQ);
        if (!has_req && |(req_valid & (NREQ'(1) << cand))) begin
          grant   = cand;
          has_req = 1'b1;
        end
      end
    end
  end

  always_comb begin
    opc_sh      = req_opc >> (32'd2 * 32'(grant));
    a_sh        = req_a >> (32'd16 * 32'(grant));
    b_sh        = req_b >> (32'd16 * 32'(grant));
    bf16_opc    = has_req ? opc_sh[1:0] : '0;
    bf16_a      = has_req ? a_sh[15:0] : '0;
    bf16_b      = has_req ? b_sh[15:0] : '0;
    bf16_isSqrt = has_req & |(req_sqrt & (NREQ'(1) << grant));
    bf16_iv     = issue_en & |(req_valid & (NREQ'(1) << grant));
    req_ready   = issue_en ? (NREQ'(bf16_ir) << grant) : '0;
    accept      = bf16_iv & bf16_ir;
  end

  // Results are neither routed nor drained while the unit is being killed.
  always_comb begin
    rsp_valid = '0;
    bf16_or   = 1'b0;
    if (!kill_q && !abort) begin
      if (nonempty) begin
        rsp_valid = NREQ'(bf16_ov) << head;
        bf16_or   = |(rsp_ready & (NREQ'(1) << head));
      end else begin
        bf16_or   = bf16_ov;
      end
    end
    pop      = nonempty & bf16_ov & bf16_or;
    spurious = !nonempty & bf16_ov & !kill_q & !abort;
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      kill_q <= abort;
      if (spurious) err_q <= 1'b1;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        lock   <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= ptr_inc(wr_ptr);
          rr_ptr <= TW'((32'(grant) + 32'd1) % NREQ);
          lock   <= 1'b0;
        end else if (bf16_iv && !bf16_ir) begin
          lock    <= 1'b1;
          lock_id <= grant;
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (accept && !pop)      count <= count + CW'(1);
        else if (!accept && pop) count <= count - CW'(1);
      end
    end
  end

  assign rsp_y        = bf16_y;
  assign busy         = nonempty | kill_q;
  assign bf16_kill    = kill_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_bf16_share_arbiter.sv
// Directed bench for bf16_share_arbiter: a queue-based ownership model checked every
// cycle, plus hand-computed literal expectations along each scenario.
module tb_bf16_share_arbiter;
  localparam int NREQ = 2;
  localparam int MAXO = 4;
  localparam int TW   = 2;

  logic clk = 1'b0;
  logic rstn;
  logic [NREQ-1:0] req_valid, req_ready, req_sqrt, rsp_valid, rsp_ready;
  logic [2*NREQ-1:0] req_opc;
  logic [16*NREQ-1:0] req_a, req_b;
  logic [15:0] rsp_y, bf16_a, bf16_b, bf16_y;
  logic abort, busy, err_spurious, bf16_isSqrt, bf16_iv, bf16_ir, bf16_ov, bf16_or, bf16_kill;
  logic [1:0] bf16_opc;

  always #5 clk = ~clk;

  bf16_share_arbiter #(.NREQ(NREQ), .MAX_OUTSTANDING(MAXO), .TW(TW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
    .req_a(req_a), .req_b(req_b), .req_sqrt(req_sqrt), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .abort(abort), .busy(busy),
    .err_spurious(err_spurious), .bf16_opc(bf16_opc), .bf16_a(bf16_a), .bf16_b(bf16_b),
    .bf16_isSqrt(bf16_isSqrt), .bf16_iv(bf16_iv), .bf16_ir(bf16_ir), .bf16_y(bf16_y),
    .bf16_ov(bf16_ov), .bf16_or(bf16_or), .bf16_kill(bf16_kill)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: queue of owners in flight, round-robin pointer, stall lock, kill flag.
  int mq[$];
  int m_rr, m_lid;
  bit m_lock, m_kill, m_err;

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_lid = 0; m_lock = 0; m_kill = 0; m_err = 0;
  endtask

  int g;
  bit has, en, iv, acc, pp, spur, ne, e_or;
  logic [NREQ-1:0] e_ready, e_rsp;
  logic [34:0] e_data;

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rstn) begin model_reset(); continue; end
      ne  = (mq.size() != 0);
      en  = (mq.size() != MAXO) && !m_kill && !abort;
      has = 0;
      g   = m_rr;
      if (m_lock) begin
        g = m_lid; has = 1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_rr + k) % NREQ;
          if (!has && req_valid[idx]) begin g = idx; has = 1; end
        end
      end
      iv = en && req_valid[g];
      e_ready = '0;
      if (en && bf16_ir) e_ready[g] = 1'b1;
      e_data = has ? {req_opc[2*g +: 2], req_a[16*g +: 16], req_b[16*g +: 16], req_sqrt[g]} : '0;
      e_rsp = '0;
      e_or  = 0;
      if (!m_kill && !abort) begin
        if (ne) begin
          e_rsp[mq[0]] = bf16_ov;
          e_or = rsp_ready[mq[0]];
        end else begin
          e_or = bf16_ov;
        end
      end
      acc  = iv && bf16_ir;
      pp   = ne && bf16_ov && e_or;
      spur = !ne && bf16_ov && !m_kill && !abort;
      chk("m_ready", req_ready & req_valid, e_ready & req_valid);
      chk("m_iv", bf16_iv, iv);
      chk("m_payload", {bf16_opc, bf16_a, bf16_b, bf16_isSqrt}, e_data);
      chk("m_rsp_valid", rsp_valid, e_rsp);
      chk("m_or", bf16_or, e_or);
      chk("m_rsp_y", rsp_y, bf16_y);
      chk("m_busy", busy, ne || m_kill);
      chk("m_kill", bf16_kill, m_kill);
      chk("m_err", err_spurious, m_err);
      @(posedge clk);
      if (!rstn) begin model_reset(); continue; end
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(g);
        m_rr = (g + 1) % NREQ;
        m_lock = 0;
      end else if (iv && !bf16_ir) begin
        m_lock = 1;
        m_lid = g;
      end
      if (spur) m_err = 1;
      if (abort) begin
        mq.delete();
        m_lock = 0;
      end
      m_kill = abort;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic sq);
    req_opc[2*i +: 2] = opc;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_sqrt[i] = sq;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_opc = '0; req_a = '0; req_b = '0; req_sqrt = '0;
    rsp_ready = '0; abort = 1'b0; bf16_ir = 1'b0; bf16_y = '0; bf16_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_iv", bf16_iv, 0);
    chk("rst_kill", bf16_kill, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);

    // 1: single op from requester 0
    set_req(0, 2'd0, 16'h3F80, 16'h4000, 1'b0);
    req_valid = 2'b01; bf16_ir = 1'b1;
    #2;
    chk("t1_iv", bf16_iv, 1);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_a", bf16_a, 16'h3F80);
    chk("t1_b", bf16_b, 16'h4000);
    cyc(); req_valid = '0; bf16_ir = 1'b0;
    #2 chk("t1_busy", busy, 1);
    cyc(); bf16_ov = 1'b1; bf16_y = 16'h4040; rsp_ready = 2'b01;
    #2;
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_y", rsp_y, 16'h4040);
    chk("t1_or", bf16_or, 1);
    cyc(); bf16_ov = 1'b0; rsp_ready = '0;
    #2 chk("t1_busy_after", busy, 0);

    // reset while an op is outstanding
    req_valid = 2'b10; bf16_ir = 1'b1;
    cyc(); req_valid = '0; bf16_ir = 1'b0;
    #1 chk("rm_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_kill", bf16_kill, 0);
    cyc(); rstn = 1'b1;

    // 2: both requesters valid for 6 ops, results returned in order
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        req_valid = 2'b11; bf16_ir = 1'b1;
        set_req(0, 2'd1, 16'h1000 + 16'(k), 16'h0100, 1'b0);
        set_req(1, 2'd1, 16'h2000 + 16'(k), 16'h0200, 1'b0);
      end else begin
        req_valid = '0; bf16_ir = 1'b0;
      end
      bf16_ov = (k >= 1); bf16_y = 16'h5000 + 16'(k); rsp_ready = 2'b11;
      #2;
      if (k < 6) begin
        chk("t2_ready", req_ready, 2'b01 << (k % 2));
        chk("t2_a", bf16_a, (k % 2 == 1) ? 16'h2000 + 16'(k) : 16'h1000 + 16'(k));
      end
      if (k >= 1) chk("t2_rsp_valid", rsp_valid, 2'b01 << ((k - 1) % 2));
      cyc();
    end
    bf16_ov = 1'b0; rsp_ready = '0;
    #2 chk("t2_busy", busy, 0);
    chk("t2_err", err_spurious, 0);

    // 3: stalled grant on requester 1 holds while requester 0 asserts
    set_req(1, 2'd2, 16'hAAAA, 16'h5555, 1'b1);
    set_req(0, 2'd3, 16'h1111, 16'h2222, 1'b0);
    req_valid = 2'b10; bf16_ir = 1'b0;
    #2;
    chk("t3_iv", bf16_iv, 1);
    chk("t3_a0", bf16_a, 16'hAAAA);
    cyc(); req_valid = 2'b11;
    #2 chk("t3_a1", bf16_a, 16'hAAAA);
    chk("t3_sqrt", bf16_isSqrt, 1);
    cyc();
    #2 chk("t3_a2", bf16_a, 16'hAAAA);
    chk("t3_ready_stall", req_ready, 2'b00);
    cyc(); bf16_ir = 1'b1;
    #2 chk("t3_ready_1", req_ready, 2'b10);
    chk("t3_a3", bf16_a, 16'hAAAA);
    cyc();
    #2 chk("t3_ready_0", req_ready, 2'b01);
    chk("t3_a4", bf16_a, 16'h1111);
    cyc(); req_valid = '0; bf16_ir = 1'b0; bf16_ov = 1'b1; rsp_ready = 2'b11; bf16_y = 16'h6001;
    #2 chk("t3_rsp1", rsp_valid, 2'b10);
    cyc(); bf16_y = 16'h6002;
    #2 chk("t3_rsp0", rsp_valid, 2'b01);
    cyc(); bf16_ov = 1'b0; rsp_ready = '0;

    // 4: fill the FIFO, pop once, issue resumes a cycle later
    req_valid = 2'b01; bf16_ir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 2'd0, 16'h7000 + 16'(k), 16'h0001, 1'b0);
      #2 chk("t4_fill_ready", req_ready, 2'b01);
      cyc();
    end
    #2;
    chk("t4_full_iv", bf16_iv, 0);
    chk("t4_full_ready", req_ready, 2'b00);
    chk("t4_full_busy", busy, 1);
    cyc(); bf16_ov = 1'b1; rsp_ready = 2'b01; bf16_y = 16'h7777;
    #2;
    chk("t4_popcyc_iv", bf16_iv, 0);
    chk("t4_popcyc_rsp", rsp_valid, 2'b01);
    cyc(); bf16_ov = 1'b0;
    #2;
    chk("t4_resume_iv", bf16_iv, 1);
    chk("t4_resume_ready", req_ready, 2'b01);
    cyc(); req_valid = '0; bf16_ir = 1'b0; bf16_ov = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2 chk("t4_drain_rsp", rsp_valid, 2'b01);
      cyc();
    end
    bf16_ov = 1'b0; rsp_ready = '0;
    #2 chk("t4_busy", busy, 0);

    // 5: abort with 2 ops outstanding, then a late result
    req_valid = 2'b01; bf16_ir = 1'b1;
    cyc(); cyc();
    req_valid = '0; abort = 1'b1; bf16_ov = 1'b1; rsp_ready = 2'b01;
    #2;
    chk("t5_abort_kill", bf16_kill, 0);
    chk("t5_abort_or", bf16_or, 0);
    chk("t5_abort_rsp", rsp_valid, 2'b00);
    cyc(); abort = 1'b0; bf16_ov = 1'b0; req_valid = 2'b01;
    #2;
    chk("t5_kill", bf16_kill, 1);
    chk("t5_kill_busy", busy, 1);
    chk("t5_kill_iv", bf16_iv, 0);
    chk("t5_kill_ready", req_ready, 2'b00);
    cyc(); req_valid = '0; bf16_ir = 1'b0;
    #2;
    chk("t5_kill_done", bf16_kill, 0);
    chk("t5_busy", busy, 0);
    cyc(); bf16_ov = 1'b1; bf16_y = 16'h0BAD;
    #2;
    chk("t5_late_rsp", rsp_valid, 2'b00);
    chk("t5_late_or", bf16_or, 1);
    cyc(); bf16_ov = 1'b0;
    #2 chk("t5_err", err_spurious, 1);

    // 6: result held while requester 0 is not ready
    req_valid = 2'b01; bf16_ir = 1'b1;
    set_req(0, 2'd1, 16'h3C00, 16'h3C00, 1'b0);
    cyc(); req_valid = '0; bf16_ir = 1'b0; bf16_ov = 1'b1; bf16_y = 16'h1234; rsp_ready = '0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t6_hold_or", bf16_or, 0);
      chk("t6_hold_rsp", rsp_valid, 2'b01);
      cyc();
    end
    rsp_ready = 2'b01;
    #2 chk("t6_or", bf16_or, 1);
    cyc(); bf16_ov = 1'b0; rsp_ready = '0;
    #2 chk("t6_busy", busy, 0);

    // reset clears the sticky error
    rstn = 1'b0;
    #1 chk("end_err_cleared", err_spurious, 0);
    cyc(); rstn = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
